// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte sequencer: byte width, default
// parameters and the 3-bit sequencer state encoding.
package spi_pkg;

  localparam int BYTE_W          = 8;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_GAP_CYC     = 2;
  localparam int DEF_TIMEOUT_CYC = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_GAP     = 3'd6,
    ST_ABORT   = 3'd7
  } seq_state_t;

  // Larger of two integers, used to size the shared setup/gap counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with wrap-flag pointers. A push into a full FIFO is
// refused, a pop from an empty FIFO is ignored; head is the oldest entry.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Equal pointers mean empty; same index with opposite wrap flag means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer advance; each side is gated by its own flag only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Byte-stream front end for the SPI master: queues TX bytes, launches one
// transfer at a time, waits for chip select to fall and rise again, and
// queues the received byte. A stuck chip select aborts the byte instead of
// hanging the sequencer.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr,
  output logic [BYTE_W-1:0] spi_buffer_in,
  output logic              spi_enable,
  input  logic              spi_cs,
  input  logic [BYTE_W-1:0] spi_buffer_out
);

  localparam int CNT_W = $clog2(max2(SETUP_CYC, GAP_CYC) + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_nxt;

  logic              tx_full;
  logic              tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic              rx_full;
  logic              rx_empty;
  logic              tx_pop;
  logic              rx_push;

  // The TX head leaves the FIFO only once its transfer is finished or given
  // up, so spi_buffer_in never changes under the master mid-transfer.
  assign rx_push   = (state == ST_CAPTURE) && !rx_full;
  assign tx_pop    = rx_push || (state == ST_ABORT);
  assign timer_nxt = timer + 1'b1;

  assign tx_ready  = ~tx_full;
  assign rx_valid  = ~rx_empty;
  assign busy      = (state != ST_IDLE) || !tx_empty;

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_head)
  );

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (spi_buffer_out),
    .pop       (rx_ready),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_data)
  );

  // Sequencer FSM with registered master handshake, timeout timer and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      timer         <= '0;
      spi_enable    <= 1'b0;
      spi_buffer_in <= '0;
      timeout_err   <= 1'b0;
    end else begin
      spi_enable <= 1'b0;
      // A clear is overridden below if an abort happens in the same cycle.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!tx_empty) begin
            spi_buffer_in <= tx_head;
            cnt           <= '0;
            state         <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == CNT_W'(SETUP_CYC - 1)) begin
            spi_enable <= 1'b1;
            state      <= ST_START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_START: begin
          timer <= '0;
          state <= ST_WAIT_LO;
        end

        ST_WAIT_LO: begin
          if (!spi_cs) begin
            timer <= '0;
            state <= ST_WAIT_HI;
          end else begin
            timer <= timer_nxt;
            if (timer_nxt == TMR_W'(TIMEOUT_CYC)) state <= ST_ABORT;
          end
        end

        ST_WAIT_HI: begin
          if (spi_cs) begin
            state <= ST_CAPTURE;
          end else begin
            timer <= timer_nxt;
            if (timer_nxt == TMR_W'(TIMEOUT_CYC)) state <= ST_ABORT;
          end
        end

        // Stays here while the RX FIFO is full so the received byte is kept.
        ST_CAPTURE: begin
          if (!rx_full) begin
            cnt   <= '0;
            state <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
          end
        end

        ST_GAP: begin
          if (cnt == CNT_W'(GAP_CYC - 1)) state <= ST_IDLE;
          else                            cnt   <= cnt + 1'b1;
        end

        ST_ABORT: begin
          timeout_err <= 1'b1;
          cnt         <= '0;
          state       <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
